// File: rtl/avm_led_seq_pkg.sv
// Shared types and constants for the Avalon-MM LED sequencer.
// Readback states are only reached when AVM_LED_SEQ_READBACK_EN is defined.
package avm_led_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWr,
    StRd,
    StChk
  } state_e;

  localparam logic MODE_WALK  = 1'b0;
  localparam logic MODE_COUNT = 1'b1;

  localparam logic [7:0] ERR_MAX = 8'd255;

endpackage

// File: rtl/avm_led_seq_tick.sv
// Enable-gated divider: one-cycle tick every TICK_DIV clocks while enable is high.
module avm_led_seq_tick #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(TICK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == CntMax);
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/avm_led_sequencer.sv
// Avalon-MM master writing a walking-one / counting LED pattern to the PIO data register.
// Define AVM_LED_SEQ_READBACK_EN to read each write back and count mismatches.
module avm_led_sequencer
  import avm_led_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned PIO_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              mode,
  output logic [1:0]        avm_address,
  output logic              avm_write,
  output logic              avm_read,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  output logic [DATA_W-1:0] pattern,
  output logic              busy,
  output logic              overrun,
  output logic [7:0]        err_count
);

  logic              tick;
  state_e            state_q, state_d;
  logic [DATA_W-1:0] pattern_q, pattern_d, nxt;
  logic [31:0]       wdata_q, wdata_d;
  logic              overrun_q, overrun_d;

`ifdef AVM_LED_SEQ_READBACK_EN
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        err_q, err_d;
`endif

  avm_led_seq_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .tick  (tick)
  );

  always_comb begin
    if (mode == MODE_COUNT) begin
      nxt = pattern_q + DATA_W'(1);
    end else if (pattern_q == '0) begin
      nxt = DATA_W'(1);
    end else begin
      nxt = {pattern_q[DATA_W-2:0], pattern_q[DATA_W-1]};
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    wdata_d   = wdata_q;
    // Any tick outside IDLE is dropped; busy is the registered state.
    overrun_d = overrun_q | (tick && (state_q != StIdle));
`ifdef AVM_LED_SEQ_READBACK_EN
    rdata_d   = rdata_q;
    err_d     = err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (tick) begin
          pattern_d = nxt;
          wdata_d   = 32'(nxt);
          state_d   = StWr;
        end
      end
      StWr: begin
        if (!avm_waitrequest) begin
`ifdef AVM_LED_SEQ_READBACK_EN
          state_d = StRd;
`else
          state_d = StIdle;
`endif
        end
      end
`ifdef AVM_LED_SEQ_READBACK_EN
      StRd: begin
        if (!avm_waitrequest) begin
          rdata_d = avm_readdata[DATA_W-1:0];
          state_d = StChk;
        end
      end
      StChk: begin
        if ((rdata_q != pattern_q) && (err_q != ERR_MAX)) begin
          err_d = err_q + 8'd1;
        end
        state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      pattern_q <= '0;
      wdata_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      wdata_q   <= wdata_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef AVM_LED_SEQ_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= '0;
    end else begin
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign avm_read  = (state_q == StRd);
  assign err_count = err_q;
`else
  assign avm_read  = 1'b0;
  assign err_count = '0;
`endif

  assign avm_address   = 2'(PIO_ADDR);
  assign avm_write     = (state_q == StWr);
  assign avm_writedata = wdata_q;
  assign pattern       = pattern_q;
  assign busy          = (state_q != StIdle);
  assign overrun       = overrun_q;

  logic unused_rdata;
  assign unused_rdata = ^avm_readdata;

endmodule

// File: tb/tb_avm_led_sequencer.sv
// Randomized self-checking bench for avm_led_sequencer against a pattern-level model
// and a behavioural Avalon-MM slave; honours AVM_LED_SEQ_READBACK_EN.
module tb_avm_led_sequencer;

  localparam int unsigned TickDiv = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        mode = 1'b0;
  logic [1:0]  avm_address;
  logic        avm_write;
  logic        avm_read;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = '0;
  logic        avm_waitrequest = 1'b0;
  logic [7:0]  pattern;
  logic        busy;
  logic        overrun;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Slave model state
  int          wr_stall = 0;
  int          rd_stall = 0;
  int          stall_left = 0;
  int          cur_len = 0;
  int          last_wr_len = 0;
  bit          in_acc = 0;
  bit          wr_unstable = 0;
  bit          both_err = 0;
  bit          read_seen = 0;
  logic [31:0] first_wd = '0;
  logic [31:0] mem = '0;
  logic [31:0] rd_mask = '0;
  logic [31:0] writes[$];
  int          wr_start[$];

  logic [7:0]  model_pat;

  avm_led_sequencer #(
    .TICK_DIV(TickDiv),
    .DATA_W  (8),
    .PIO_ADDR(0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .mode           (mode),
    .avm_address    (avm_address),
    .avm_write      (avm_write),
    .avm_read       (avm_read),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .pattern        (pattern),
    .busy           (busy),
    .overrun        (overrun),
    .err_count      (err_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: stalls each access by a programmable count, records accepted writes.
  always @(negedge clk) begin
    if (avm_write === 1'b1 && avm_read === 1'b1) both_err = 1;
    if (avm_read === 1'b1) read_seen = 1;
    if (avm_write === 1'b1 || avm_read === 1'b1) begin
      if (!in_acc) begin
        in_acc     = 1;
        stall_left = (avm_write === 1'b1) ? wr_stall : rd_stall;
        cur_len    = 0;
        first_wd   = avm_writedata;
        if (avm_write === 1'b1) wr_start.push_back(cyc);
      end
      cur_len++;
      if (avm_write === 1'b1 && avm_writedata !== first_wd) wr_unstable = 1;
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_acc = 0;
        if (avm_write === 1'b1) begin
          writes.push_back(avm_writedata);
          mem = avm_writedata;
          last_wr_len = cur_len;
        end else begin
          avm_readdata = mem ^ rd_mask;
        end
      end
    end else begin
      avm_waitrequest = 1'b0;
      in_acc = 0;
    end
  end

  function automatic logic [7:0] model_next(input logic [7:0] p, input logic m);
    int v;
    v = int'(p);
    if (m) v = (v + 1) % 256;
    else if (v == 0) v = 1;
    else v = ((v * 2) % 256) + (v / 128);
    return 8'(v);
  endfunction

  task automatic do_reset();
    reset  = 1'b1;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (writes.size() >= n) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (pattern !== 8'h00) begin errors++; $display("FAIL reset_pattern: got %h want 00", pattern); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL reset_err: got %0d want 0", err_count); end
    checks++; if (avm_write !== 1'b0 || avm_read !== 1'b0) begin
      errors++; $display("FAIL reset_req: got write=%b read=%b want 0 0", avm_write, avm_read);
    end
    checks++; if (avm_writedata !== 32'h0) begin errors++; $display("FAIL reset_wdata: got %h want 0", avm_writedata); end
    checks++; if (avm_address !== 2'd0) begin errors++; $display("FAIL reset_addr: got %0d want 0", avm_address); end
    reset = 1'b0;
  endtask

  task automatic test_walk();
    bit ok;
    int c0;
    int bad_period;
    logic [31:0] got;
    logic [7:0] p;
    do_reset();
    writes.delete(); wr_start.delete();
    mode = 1'b0;
    c0 = cyc;
    enable = 1'b1;
    wait_writes(10, 10 * TickDiv + 20, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL walk_timeout: got %0d writes want 10", writes.size()); end
    p = 8'h00;
    for (int k = 0; k < 10; k++) begin
      p = model_next(p, 1'b0);
      got = 'x;
      if (k < writes.size()) got = writes[k];
      checks++;
      if (got !== {24'h0, p}) begin errors++; $display("FAIL walk_data[%0d]: got %h want %h", k, got, p); end
    end
    model_pat = p;
    checks++;
    if (wr_start.size() < 1 || wr_start[0] != c0 + int'(TickDiv)) begin
      errors++; $display("FAIL walk_latency: got first write at +%0d want +%0d",
                         (wr_start.size() > 0) ? wr_start[0] - c0 : -1, TickDiv);
    end
    bad_period = 0;
    for (int k = 0; k + 1 < wr_start.size(); k++) begin
      if (wr_start[k+1] - wr_start[k] != int'(TickDiv)) bad_period++;
    end
    checks++; if (bad_period != 0) begin errors++; $display("FAIL walk_period: got %0d bad intervals want 0", bad_period); end
    repeat (10) @(negedge clk);
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL walk_err: got %0d want 0", err_count); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL walk_overrun: got %b want 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL walk_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_random_mode();
    bit ok;
    int base;
    logic [31:0] got;
    logic [7:0] exp;
    base = writes.size();
    for (int k = 0; k < 24; k++) begin
      mode = ($urandom_range(0, 1) != 0);
      enable = 1'b1;
      wait_writes(base + k + 1, 4 * TickDiv + 10, ok);
      exp = model_next(model_pat, mode);
      got = 'x;
      if (ok) got = writes[base + k];
      checks++;
      if (got !== {24'h0, exp}) begin
        errors++; $display("FAIL rand_data[%0d]: got %h want %h (mode %b)", k, got, exp, mode);
      end
      model_pat = exp;
    end
    enable = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (pattern !== model_pat) begin errors++; $display("FAIL rand_pattern: got %h want %h", pattern, model_pat); end
  endtask

  task automatic test_count_wrap();
    bit ok;
    int bad;
    logic [31:0] got;
    logic [7:0] p;
    do_reset();
    writes.delete(); wr_start.delete();
    mode = 1'b1;
    enable = 1'b1;
    wait_writes(256, 256 * TickDiv + 40, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL count_timeout: got %0d writes want 256", writes.size()); end
    bad = 0;
    p = 8'h00;
    for (int k = 0; k < 256; k++) begin
      p = model_next(p, 1'b1);
      if (k >= writes.size() || writes[k] !== {24'h0, p}) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL count_seq: got %0d wrong writes want 0", bad); end
    got = 'x; if (writes.size() > 253) got = writes[253];
    checks++; if (got !== 32'h0000_00FE) begin errors++; $display("FAIL count_fe: got %h want 000000fe", got); end
    got = 'x; if (writes.size() > 254) got = writes[254];
    checks++; if (got !== 32'h0000_00FF) begin errors++; $display("FAIL count_ff: got %h want 000000ff", got); end
    got = 'x; if (writes.size() > 255) got = writes[255];
    checks++; if (got !== 32'h0000_0000) begin errors++; $display("FAIL count_wrap00: got %h want 00000000", got); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_stall();
    bit ok;
    bit ok2;
    do_reset();
    writes.delete(); wr_start.delete();
    wr_stall = 3; wr_unstable = 0; last_wr_len = 0;
    mode = 1'b0;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (avm_write === 1'b1) begin ok = 1; break; end
    end
    // Stop further ticks; the in-flight write must still complete.
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL stall_start: got no write want write"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stall_busy: got %b want 1", busy); end
    wait_writes(1, 20, ok2);
    repeat (8) @(negedge clk);
    checks++; if (writes.size() != 1) begin errors++; $display("FAIL stall_count: got %0d writes want 1", writes.size()); end
    checks++; if (last_wr_len != 4) begin errors++; $display("FAIL stall_len: got %0d cycles want 4", last_wr_len); end
    checks++; if (wr_unstable) begin errors++; $display("FAIL stall_stable: got unstable data want stable"); end
    checks++; if (writes.size() < 1 || writes[0] !== 32'h1) begin
      errors++; $display("FAIL stall_data: got %h want 00000001", (writes.size() > 0) ? writes[0] : 32'hx);
    end
    checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL stall_end: got overrun=%b busy=%b want 0 0", overrun, busy);
    end
    wr_stall = 0;
  endtask

  task automatic test_overrun();
    bit ok;
    do_reset();
    writes.delete(); wr_start.delete();
    wr_stall = 6;
    mode = 1'b0;
    enable = 1'b1;
    wait_writes(1, 30, ok);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL ovr_timeout: got %0d writes want 1", writes.size()); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    checks++; if (writes.size() != 1) begin errors++; $display("FAIL ovr_count: got %0d writes want 1", writes.size()); end
    wr_stall = 0;
    enable = 1'b1;
    wait_writes(2, 4 * TickDiv + 10, ok);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    // The dropped tick must not have advanced the pattern.
    checks++; if (writes.size() < 2 || writes[1] !== 32'h2) begin
      errors++; $display("FAIL ovr_next: got %h want 00000002", (writes.size() > 1) ? writes[1] : 32'hx);
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_readback();
    bit ok;
    do_reset();
    writes.delete(); wr_start.delete();
    read_seen = 0;
`ifdef AVM_LED_SEQ_READBACK_EN
    rd_mask = 32'h1;
    mode = 1'b0;
    enable = 1'b1;
    wait_writes(10, 10 * TickDiv + 20, ok);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (err_count !== 8'd10) begin errors++; $display("FAIL rb_err10: got %0d want 10", err_count); end
    checks++; if (!read_seen) begin errors++; $display("FAIL rb_read: got no read want reads"); end
    enable = 1'b1;
    wait_writes(300, 290 * TickDiv + 60, ok);
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL rb_timeout: got %0d writes want 300", writes.size()); end
    checks++; if (err_count !== 8'd255) begin errors++; $display("FAIL rb_sat: got %0d want 255", err_count); end
    rd_mask = 32'h0;
`else
    mode = 1'b1;
    enable = 1'b1;
    wait_writes(5, 5 * TickDiv + 20, ok);
    enable = 1'b0;
    repeat (6) @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL rb_timeout: got %0d writes want 5", writes.size()); end
    checks++; if (err_count !== 8'd0) begin errors++; $display("FAIL rb_err_off: got %0d want 0", err_count); end
    checks++; if (read_seen) begin errors++; $display("FAIL rb_no_read: got read want none"); end
`endif
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    writes.delete(); wr_start.delete();
    rd_mask = 32'h1;
`ifdef AVM_LED_SEQ_READBACK_EN
    rd_stall = 5;
`else
    wr_stall = 5;
`endif
    mode = 1'b0;
    enable = 1'b1;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
`ifdef AVM_LED_SEQ_READBACK_EN
      if (avm_read === 1'b1 && avm_waitrequest === 1'b1) begin ok = 1; break; end
`else
      if (avm_write === 1'b1 && avm_waitrequest === 1'b1) begin ok = 1; break; end
`endif
    end
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    checks++; if (!ok) begin errors++; $display("FAIL mid_start: got no stalled access want one"); end
    checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin
      errors++; $display("FAIL mid_req: got write=%b read=%b want 0 0", avm_write, avm_read);
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (pattern !== 8'h00) begin errors++; $display("FAIL mid_pattern: got %h want 00", pattern); end
    checks++; if (err_count !== 8'h00) begin errors++; $display("FAIL mid_err: got %0d want 0", err_count); end
    reset = 1'b0;
    rd_stall = 0; wr_stall = 0; rd_mask = 32'h0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish want finish within 40000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_walk();
    test_random_mode();
    test_count_wrap();
    test_stall();
    test_overrun();
    test_readback();
    test_reset_mid();
    checks++; if (both_err) begin errors++; $display("FAIL bus_excl: got write and read together want never"); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
